regfile_mp: RTL

//  Parametrised multi-port register file: NR async read ports, NW sync write ports.

---
 rtl/regfile_pkg.sv | 41 ++++
 rtl/regfile_scoreboard.sv | 62 ++++++
 rtl/regfile_mp.sv | 132 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Package regfile_pkg
// Purpose : shared constants and helpers for the multi-port register file.
// Contents:
//   DW_DEF/AW_DEF/NR_DEF/NW_DEF  default data width, address width, read ports, write ports
//   MAX_NW/MAX_AW                widest write-port count / address width wr_sel can handle
//   wr_sel_t                     {hit, idx} result of a write-port lookup
//   wr_sel()                     highest-index enabled write port whose address matches addr
package regfile_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int NR_DEF = 2;
  localparam int NW_DEF = 2;

  // wr_sel works on zero-padded vectors so one function serves any NW <= MAX_NW
  // and AW <= MAX_AW.
  localparam int MAX_NW = 16;
  localparam int MAX_AW = 16;
  localparam int SEL_W  = 4;

  typedef struct packed {
    logic             hit;
    logic [SEL_W-1:0] idx;
  } wr_sel_t;

  // Later ports overwrite earlier matches, so the highest matching index wins.
  function automatic wr_sel_t wr_sel(input logic [MAX_AW-1:0]        addr,
                                     input logic [MAX_NW-1:0]        en,
                                     input logic [MAX_NW*MAX_AW-1:0] addrs);
    wr_sel_t s;
    s = '0;
    for (int j = 0; j < MAX_NW; j++) begin
      if (en[j] && (addrs[j*MAX_AW +: MAX_AW] == addr)) begin
        s.hit = 1'b1;
        s.idx = SEL_W'(j);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Module regfile_scoreboard
// Purpose : one busy bit per register, tracking destinations of in-flight ops.
// Ports   :
//   clk         clock
//   clr         asynchronous active-high reset, clears every busy bit
//   wr_en       per-port write enable (NW)
//   wr_addr     packed write addresses (NW*AW); a write clears its target's busy bit
//   issue_en    an op was issued this cycle
//   issue_addr  destination of the issued op; its busy bit is set
//   busy        current busy vector (2**AW)
//   any_busy    OR of all busy bits
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int NW      = NW_DEF,
  parameter int R0_ZERO = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  output logic [2**AW-1:0] busy,
  output logic             any_busy
);

  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      logic clear_hit;
      logic set_hit;

      always_comb begin
        clear_hit = 1'b0;
        for (int j = 0; j < NW; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(gi))) clear_hit = 1'b1;
        end
      end

      assign set_hit = issue_en && (issue_addr == AW'(gi)) && !((R0_ZERO != 0) && (gi == 0));

      // A same-cycle issue means a newer op now owns the register, so set beats clear.
      assign busy_next[gi] = set_hit ? 1'b1 : (clear_hit ? 1'b0 : busy_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge clr) begin
    if (clr) busy_reg <= '0;
    else     busy_reg <= busy_next;
  end

  assign busy     = busy_reg;
  assign any_busy = |busy_reg;

endmodule

// File: rtl/regfile_mp.sv
// Module regfile_mp
// Purpose : parametrised register file with NR combinational read ports, NW
//           synchronous write ports and a per-register busy scoreboard.
// Ports   :
//   clk         clock; all state updates on posedge
//   clr         asynchronous active-high reset (registers and busy bits to 0)
//   rd_addr     NR*AW read addresses, port i at [i*AW +: AW]
//   rd_data     NR*DW read data
//   rd_busy     NR busy bits of the read addresses
//   wr_en       NW write enables
//   wr_addr     NW*AW write addresses
//   wr_data     NW*DW write data
//   issue_en    mark issue_addr busy
//   issue_addr  destination register of the issued op
//   any_busy    OR of all busy bits
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int NR      = NR_DEF,
  parameter int NW      = NW_DEF,
  parameter int R0_ZERO = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_busy,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  output logic             any_busy
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;

  regfile_scoreboard #(
    .AW      (AW),
    .NW      (NW),
    .R0_ZERO (R0_ZERO)
  ) u_scoreboard (
    .clk        (clk),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .busy       (busy),
    .any_busy   (any_busy)
  );

  // Ports are visited in ascending order, so the last (highest) enabled port
  // targeting an address is the one whose write lands.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && !((R0_ZERO != 0) && (wr_addr[j*AW +: AW] == '0))) begin
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [MAX_NW-1:0]        wr_en_ext;
  logic [MAX_NW*MAX_AW-1:0] wr_addr_ext;

  always_comb begin
    wr_en_ext   = '0;
    wr_addr_ext = '0;
    for (int j = 0; j < NW; j++) begin
      wr_en_ext[j]                    = wr_en[j];
      wr_addr_ext[j*MAX_AW +: AW]     = wr_addr[j*AW +: AW];
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_rd
      logic [AW-1:0] ra;
      logic          is_zero;
      logic [DW-1:0] port_data;
      logic          port_busy;

      assign ra      = rd_addr[gi*AW +: AW];
      assign is_zero = (R0_ZERO != 0) && (ra == '0);

`ifdef REGFILE_BYPASS_EN
      logic [MAX_AW-1:0] ra_ext;
      wr_sel_t           sel;

      always_comb begin
        ra_ext         = '0;
        ra_ext[AW-1:0] = ra;
        sel            = wr_sel(ra_ext, wr_en_ext, wr_addr_ext);
      end
`endif

      always_comb begin
        port_data = mem[ra];
        port_busy = busy[ra];
`ifdef REGFILE_BYPASS_EN
        // Forwarded data is the committing write, so the register is no longer
        // pending unless a new op claims it in the same cycle. Reset suppresses
        // forwarding because those writes are being discarded.
        if (sel.hit && !clr) begin
          port_data = wr_data[sel.idx*DW +: DW];
          port_busy = issue_en && (issue_addr == ra);
        end
`endif
        if (is_zero) begin
          port_data = '0;
          port_busy = 1'b0;
        end
      end

      assign rd_data[gi*DW +: DW] = port_data;
      assign rd_busy[gi]          = port_busy;
    end
  endgenerate

endmodule
